// File: rtl/reg_bank_arbiter.sv
// Arbitrates the single-port register bank between a 2-entry I2C strobe queue
// and a local req/gnt requester with a bounded wait before pre-emption.
module reg_bank_arbiter #(
    parameter int unsigned REGCOUNT = 32,
    parameter int unsigned AW       = 5,
    parameter int unsigned WAIT_MAX = 3
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          i2c_wr_stb,
    input  logic [AW-1:0] i2c_wr_addr,
    input  logic [7:0]    i2c_wr_data,
    input  logic          i2c_rd_stb,
    input  logic [AW-1:0] i2c_rd_addr,
    output logic [7:0]    i2c_rd_data,
    output logic          i2c_rd_valid,
    output logic          i2c_ovf,
    input  logic          loc_req,
    input  logic          loc_we,
    input  logic [AW-1:0] loc_addr,
    input  logic [7:0]    loc_wdata,
    output logic          loc_gnt,
    output logic [7:0]    loc_rdata,
    output logic          loc_rvalid,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata
);

    localparam int unsigned WCW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } op_t;

    op_t            q_ent_q [2];
    op_t            q_ent_d [2];
    logic [1:0]     q_cnt_q, q_cnt_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           ovf_q, ovf_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_loc_q, rsp_loc_d;
    logic           rsp_oor_q, rsp_oor_d;

    logic           loc_win, q_win, issue, in_range;
    op_t            win_op;
    logic [7:0]     rd_byte;

    // Slot arbitration and bank issue; everything is held quiet while in reset.
    always_comb begin
        loc_win  = reset_n && loc_req && ((q_cnt_q == 2'd0) || (wait_cnt_q == WCW'(WAIT_MAX)));
        q_win    = reset_n && !loc_win && (q_cnt_q != 2'd0);
        issue    = loc_win || q_win;
        win_op   = q_ent_q[0];
        if (loc_win) begin
            win_op.we   = loc_we;
            win_op.addr = loc_addr;
            win_op.data = loc_wdata;
        end
        in_range  = 32'(win_op.addr) < REGCOUNT;
        mem_en    = issue && in_range;
        mem_we    = mem_en && win_op.we;
        mem_addr  = mem_en ? win_op.addr : '0;
        mem_wdata = mem_en ? win_op.data : '0;
        loc_gnt   = loc_win;
    end

    // Queue update: dequeue first so a full queue can accept a same-cycle strobe.
    always_comb begin
        logic [1:0] cnt;
        q_ent_d = q_ent_q;
        ovf_d   = ovf_q;
        cnt     = q_cnt_q;
        if (q_win) begin
            q_ent_d[0] = q_ent_q[1];
            cnt        = cnt - 2'd1;
        end
        if (i2c_wr_stb) begin
            if (cnt < 2'd2) begin
                q_ent_d[cnt[0]] = '{we: 1'b1, addr: i2c_wr_addr, data: i2c_wr_data};
                cnt             = cnt + 2'd1;
            end else begin
                ovf_d = 1'b1;
            end
        end
        if (i2c_rd_stb) begin
            if (cnt < 2'd2) begin
                q_ent_d[cnt[0]] = '{we: 1'b0, addr: i2c_rd_addr, data: 8'h00};
                cnt             = cnt + 2'd1;
            end else begin
                ovf_d = 1'b1;
            end
        end
        q_cnt_d = cnt;
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!loc_req || loc_win) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WCW'(WAIT_MAX)) begin
            wait_cnt_d = wait_cnt_q + WCW'(1);
        end
        rsp_valid_d = issue && !win_op.we;
        rsp_loc_d   = loc_win;
        rsp_oor_d   = !in_range;
    end

    // Read return steers the bank byte (or 0xFF when out of range) to the owner.
    always_comb begin
        rd_byte      = rsp_oor_q ? 8'hFF : mem_rdata;
        loc_rvalid   = reset_n && rsp_valid_q && rsp_loc_q;
        i2c_rd_valid = reset_n && rsp_valid_q && !rsp_loc_q;
        loc_rdata    = loc_rvalid ? rd_byte : 8'h00;
        i2c_rd_data  = i2c_rd_valid ? rd_byte : 8'h00;
        i2c_ovf      = reset_n && ovf_q;
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            q_ent_q[0]  <= '0;
            q_ent_q[1]  <= '0;
            q_cnt_q     <= '0;
            wait_cnt_q  <= '0;
            ovf_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_loc_q   <= 1'b0;
            rsp_oor_q   <= 1'b0;
        end else begin
            q_ent_q     <= q_ent_d;
            q_cnt_q     <= q_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            ovf_q       <= ovf_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_loc_q   <= rsp_loc_d;
            rsp_oor_q   <= rsp_oor_d;
        end
    end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Directed bench for reg_bank_arbiter with a behavioural register bank (REGCOUNT=20).
module tb_reg_bank_arbiter;

    localparam int unsigned AW = 5;

    logic          clock, reset_n;
    logic          i2c_wr_stb, i2c_rd_stb, loc_req, loc_we;
    logic [AW-1:0] i2c_wr_addr, i2c_rd_addr, loc_addr, mem_addr;
    logic [7:0]    i2c_wr_data, i2c_rd_data, loc_wdata, loc_rdata, mem_wdata, mem_rdata;
    logic          i2c_rd_valid, i2c_ovf, loc_gnt, loc_rvalid, mem_en, mem_we;
    logic [7:0]    bank [32];

    int n_checks = 0;
    int n_fail   = 0;

    reg_bank_arbiter #(.REGCOUNT(20), .AW(AW), .WAIT_MAX(3)) dut (
        .clock(clock), .reset_n(reset_n),
        .i2c_wr_stb(i2c_wr_stb), .i2c_wr_addr(i2c_wr_addr), .i2c_wr_data(i2c_wr_data),
        .i2c_rd_stb(i2c_rd_stb), .i2c_rd_addr(i2c_rd_addr), .i2c_rd_data(i2c_rd_data),
        .i2c_rd_valid(i2c_rd_valid), .i2c_ovf(i2c_ovf),
        .loc_req(loc_req), .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
        .loc_gnt(loc_gnt), .loc_rdata(loc_rdata), .loc_rvalid(loc_rvalid),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single-port bank: write at the edge, read data registered for the next cycle.
    always @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) bank[i] <= 8'h00;
            mem_rdata <= 8'h00;
        end else begin
            if (mem_en && mem_we) bank[mem_addr] <= mem_wdata;
            mem_rdata <= (mem_en && !mem_we) ? bank[mem_addr] : 8'h00;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_idle();
        reset_n = 1'b1;
        i2c_wr_stb = 1'b0; i2c_wr_addr = '0; i2c_wr_data = 8'h00;
        i2c_rd_stb = 1'b0; i2c_rd_addr = '0;
        loc_req = 1'b0; loc_we = 1'b0; loc_addr = '0; loc_wdata = 8'h00;
    endtask

    task automatic test_reset();
        set_idle();
        reset_n = 1'b0; loc_req = 1'b1; i2c_wr_stb = 1'b1; i2c_rd_stb = 1'b1;
        tick(); tick(); #1;
        n_checks++;
        if ({mem_en, mem_we, loc_gnt, loc_rvalid, i2c_rd_valid, i2c_ovf} !== 6'b0) begin
            n_fail++; $display("FAIL reset_flags: got %b want 000000",
                {mem_en, mem_we, loc_gnt, loc_rvalid, i2c_rd_valid, i2c_ovf});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, loc_rdata, i2c_rd_data} !== '0) begin
            n_fail++; $display("FAIL reset_data: got %h %h %h %h want all 0",
                mem_addr, mem_wdata, loc_rdata, i2c_rd_data);
        end
        tick(); set_idle(); #1;
        n_checks++;
        if ({mem_en, loc_rvalid, i2c_rd_valid, i2c_ovf} !== 4'b0) begin
            n_fail++; $display("FAIL reset_release: got %b want 0000",
                {mem_en, loc_rvalid, i2c_rd_valid, i2c_ovf});
        end
    endtask

    task automatic test_local();
        tick(); set_idle(); loc_req = 1'b1; loc_we = 1'b1; loc_addr = 5'd3; loc_wdata = 8'hA5; #1;
        n_checks++;
        if ({loc_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 5'd3, 8'hA5}) begin
            n_fail++; $display("FAIL local_wr_issue: got gnt=%b en=%b we=%b a=%0d d=%h want 1 1 1 3 a5",
                loc_gnt, mem_en, mem_we, mem_addr, mem_wdata);
        end
        tick(); loc_we = 1'b0; #1;
        n_checks++;
        if ({loc_gnt, mem_en, mem_we, mem_addr} !== {3'b110, 5'd3}) begin
            n_fail++; $display("FAIL local_rd_issue: got gnt=%b en=%b we=%b a=%0d want 1 1 0 3",
                loc_gnt, mem_en, mem_we, mem_addr);
        end
        tick(); set_idle(); #1;
        n_checks++;
        if ({loc_rvalid, loc_rdata, i2c_rd_valid} !== {1'b1, 8'hA5, 1'b0}) begin
            n_fail++; $display("FAIL local_rd_return: got v=%b d=%h i2c_v=%b want 1 a5 0",
                loc_rvalid, loc_rdata, i2c_rd_valid);
        end
        tick(); #1;
        n_checks++;
        if (loc_rvalid !== 1'b0) begin
            n_fail++; $display("FAIL local_rvalid_pulse: got %b want 0", loc_rvalid);
        end
    endtask

    task automatic test_i2c_latency();
        tick(); set_idle(); i2c_wr_stb = 1'b1; i2c_wr_addr = 5'd7; i2c_wr_data = 8'h3C; #1;
        n_checks++;
        if (mem_en !== 1'b0) begin
            n_fail++; $display("FAIL i2c_not_same_cycle: got mem_en=%b want 0", mem_en);
        end
        tick(); set_idle(); #1;
        n_checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 5'd7, 8'h3C}) begin
            n_fail++; $display("FAIL i2c_wr_issue: got en=%b we=%b a=%0d d=%h want 1 1 7 3c",
                mem_en, mem_we, mem_addr, mem_wdata);
        end
        tick(); tick(); tick();
        i2c_rd_stb = 1'b1; i2c_rd_addr = 5'd7; #1;
        n_checks++;
        if (mem_en !== 1'b0) begin
            n_fail++; $display("FAIL i2c_rd_strobe_cycle: got mem_en=%b want 0", mem_en);
        end
        tick(); set_idle(); #1;
        n_checks++;
        if ({mem_en, mem_we, mem_addr} !== {2'b10, 5'd7}) begin
            n_fail++; $display("FAIL i2c_rd_issue: got en=%b we=%b a=%0d want 1 0 7", mem_en, mem_we, mem_addr);
        end
        tick(); #1;
        n_checks++;
        if ({i2c_rd_valid, i2c_rd_data, loc_rvalid, loc_rdata} !== {1'b1, 8'h3C, 1'b0, 8'h00}) begin
            n_fail++; $display("FAIL i2c_rd_return: got v=%b d=%h loc_v=%b loc_d=%h want 1 3c 0 00",
                i2c_rd_valid, i2c_rd_data, loc_rvalid, loc_rdata);
        end
    endtask

    task automatic test_simultaneous();
        tick(); set_idle();
        i2c_wr_stb = 1'b1; i2c_wr_addr = 5'd2; i2c_wr_data = 8'h11;
        i2c_rd_stb = 1'b1; i2c_rd_addr = 5'd2;
        tick(); set_idle(); #1;
        n_checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 5'd2, 8'h11}) begin
            n_fail++; $display("FAIL simul_write_first: got en=%b we=%b a=%0d d=%h want 1 1 2 11",
                mem_en, mem_we, mem_addr, mem_wdata);
        end
        tick(); #1;
        n_checks++;
        if ({mem_en, mem_we, mem_addr} !== {2'b10, 5'd2}) begin
            n_fail++; $display("FAIL simul_read_next: got en=%b we=%b a=%0d want 1 0 2", mem_en, mem_we, mem_addr);
        end
        tick(); #1;
        n_checks++;
        if ({i2c_rd_valid, i2c_rd_data, i2c_ovf} !== {1'b1, 8'h11, 1'b0}) begin
            n_fail++; $display("FAIL simul_read_data: got v=%b d=%h ovf=%b want 1 11 0",
                i2c_rd_valid, i2c_rd_data, i2c_ovf);
        end
    endtask

    task automatic test_overflow();
        tick(); tick(); set_idle();
        i2c_wr_stb = 1'b1; i2c_wr_addr = 5'd10; i2c_wr_data = 8'h10;
        i2c_rd_stb = 1'b1; i2c_rd_addr = 5'd11;
        tick(); set_idle();
        i2c_wr_stb = 1'b1; i2c_wr_addr = 5'd12; i2c_wr_data = 8'h12;
        loc_req = 1'b1; loc_we = 1'b1; loc_addr = 5'd5; loc_wdata = 8'h55; #1;
        n_checks++;
        if ({loc_gnt, mem_en, mem_we, mem_addr} !== {3'b011, 5'd10}) begin
            n_fail++; $display("FAIL ovf_c1_queue_wins: got gnt=%b en=%b we=%b a=%0d want 0 1 1 10",
                loc_gnt, mem_en, mem_we, mem_addr);
        end
        tick(); i2c_wr_addr = 5'd13; i2c_wr_data = 8'h13; #1;
        n_checks++;
        if ({loc_gnt, mem_we, mem_addr} !== {2'b00, 5'd11}) begin
            n_fail++; $display("FAIL ovf_c2_queue_wins: got gnt=%b we=%b a=%0d want 0 0 11", loc_gnt, mem_we, mem_addr);
        end
        tick(); i2c_wr_addr = 5'd14; i2c_wr_data = 8'h14; #1;
        n_checks++;
        if ({loc_gnt, mem_addr, i2c_rd_valid} !== {1'b0, 5'd12, 1'b1}) begin
            n_fail++; $display("FAIL ovf_c3: got gnt=%b a=%0d rd_v=%b want 0 12 1", loc_gnt, mem_addr, i2c_rd_valid);
        end
        tick(); i2c_wr_addr = 5'd15; i2c_wr_data = 8'h15; #1;
        n_checks++;
        if ({loc_gnt, mem_addr, mem_wdata, i2c_ovf} !== {1'b1, 5'd5, 8'h55, 1'b0}) begin
            n_fail++; $display("FAIL ovf_preempt: got gnt=%b a=%0d d=%h ovf=%b want 1 5 55 0",
                loc_gnt, mem_addr, mem_wdata, i2c_ovf);
        end
        tick(); set_idle(); #1;
        n_checks++;
        if ({i2c_ovf, mem_en, mem_addr} !== {2'b11, 5'd13}) begin
            n_fail++; $display("FAIL ovf_set: got ovf=%b en=%b a=%0d want 1 1 13", i2c_ovf, mem_en, mem_addr);
        end
        tick(); #1;
        n_checks++;
        if ({mem_en, mem_addr} !== {1'b1, 5'd14}) begin
            n_fail++; $display("FAIL ovf_drain: got en=%b a=%0d want 1 14", mem_en, mem_addr);
        end
        tick(); #1;
        n_checks++;
        if ({mem_en, i2c_ovf} !== 2'b01) begin
            n_fail++; $display("FAIL ovf_dropped_sticky: got en=%b ovf=%b want 0 1", mem_en, i2c_ovf);
        end
        tick(); reset_n = 1'b0;
        tick(); reset_n = 1'b1; #1;
        n_checks++;
        if (i2c_ovf !== 1'b0) begin
            n_fail++; $display("FAIL ovf_cleared: got %b want 0", i2c_ovf);
        end
    endtask

    task automatic test_fairness();
        int gnt_at;
        gnt_at = -1;
        tick(); set_idle(); i2c_wr_stb = 1'b1; i2c_wr_addr = 5'd1; i2c_wr_data = 8'h01;
        for (int k = 1; k <= 8; k++) begin
            tick();
            i2c_wr_stb  = (k <= 4);
            i2c_wr_addr = 5'(k + 1);
            i2c_wr_data = 8'(k + 1);
            loc_req = 1'b1; loc_we = 1'b0; loc_addr = 5'd1;
            #1;
            if (loc_gnt === 1'b1) begin
                gnt_at = k;
                break;
            end
        end
        n_checks++;
        if (gnt_at != 4) begin
            n_fail++; $display("FAIL fairness_gnt_cycle: got %0d want 4", gnt_at);
        end
        tick(); set_idle(); #1;
        n_checks++;
        if ({loc_rvalid, loc_rdata, mem_addr} !== {1'b1, 8'h01, 5'd4}) begin
            n_fail++; $display("FAIL fairness_rdata: got v=%b d=%h a=%0d want 1 01 4",
                loc_rvalid, loc_rdata, mem_addr);
        end
        tick(); tick(); #1;
        n_checks++;
        if (mem_en !== 1'b0) begin
            n_fail++; $display("FAIL fairness_drained: got mem_en=%b want 0", mem_en);
        end
    endtask

    task automatic test_out_of_range();
        tick(); set_idle(); loc_req = 1'b1; loc_we = 1'b0; loc_addr = 5'd31; #1;
        n_checks++;
        if ({loc_gnt, mem_en} !== 2'b10) begin
            n_fail++; $display("FAIL oor_local_issue: got gnt=%b en=%b want 1 0", loc_gnt, mem_en);
        end
        tick(); set_idle(); i2c_rd_stb = 1'b1; i2c_rd_addr = 5'd20; #1;
        n_checks++;
        if ({loc_rvalid, loc_rdata} !== {1'b1, 8'hFF}) begin
            n_fail++; $display("FAIL oor_local_data: got v=%b d=%h want 1 ff", loc_rvalid, loc_rdata);
        end
        tick(); set_idle(); #1;
        n_checks++;
        if (mem_en !== 1'b0) begin
            n_fail++; $display("FAIL oor_i2c_issue: got mem_en=%b want 0", mem_en);
        end
        tick(); loc_req = 1'b1; loc_we = 1'b1; loc_addr = 5'd19; loc_wdata = 8'h77; #1;
        n_checks++;
        if ({i2c_rd_valid, i2c_rd_data} !== {1'b1, 8'hFF}) begin
            n_fail++; $display("FAIL oor_i2c_data: got v=%b d=%h want 1 ff", i2c_rd_valid, i2c_rd_data);
        end
        n_checks++;
        if ({loc_gnt, mem_en, mem_addr} !== {2'b11, 5'd19}) begin
            n_fail++; $display("FAIL last_in_range: got gnt=%b en=%b a=%0d want 1 1 19", loc_gnt, mem_en, mem_addr);
        end
    endtask

    task automatic test_reset_cancel();
        tick(); set_idle(); loc_req = 1'b1; loc_we = 1'b0; loc_addr = 5'd19; #1;
        n_checks++;
        if ({loc_gnt, mem_en} !== 2'b11) begin
            n_fail++; $display("FAIL cancel_issue: got gnt=%b en=%b want 1 1", loc_gnt, mem_en);
        end
        tick(); reset_n = 1'b0; #1;
        n_checks++;
        if ({loc_rvalid, loc_rdata, loc_gnt, mem_en, i2c_rd_valid, i2c_ovf} !== '0) begin
            n_fail++; $display("FAIL cancel_in_reset: got v=%b d=%h gnt=%b en=%b i2c_v=%b ovf=%b want all 0",
                loc_rvalid, loc_rdata, loc_gnt, mem_en, i2c_rd_valid, i2c_ovf);
        end
        tick(); set_idle(); #1;
        n_checks++;
        if ({loc_rvalid, i2c_rd_valid} !== 2'b00) begin
            n_fail++; $display("FAIL cancel_after_reset: got loc_v=%b i2c_v=%b want 0 0", loc_rvalid, i2c_rd_valid);
        end
    endtask

    initial begin
        test_reset();
        test_local();
        test_i2c_latency();
        test_simultaneous();
        test_overflow();
        test_fairness();
        test_out_of_range();
        test_reset_cancel();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
